instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  - Instruction fetch stage directly downstream of the program counter.
//  - Samples the current PC, runs one read transaction on the instruction-memory port,
//    and holds the returned word for decode under a valid/ready handshake.
//  - Pulses pc_step on each accepted instruction so the controller can advance the PC.
//  - Honours flush from branch/jump resolution.
// PARAMETERS
//  - XLEN        32            data/address width
//  - RESET_INSTR 32'h00000013  instr value at reset and after flush (ADDI x0,x0,0 = NOP)
// PORTS
//  - clk         in   1     single clock, all state on rising edge
//  - rst_n       in   1     asynchronous, active-low reset
//  - fetch_en    in   1     permit new fetches; in-flight transaction always completes
//  - pc          in   XLEN  current PC from pc register
//  - flush       in   1     discard held/in-flight instruction; refetch from pc
//  - imem_req    out  1     read request; held high until imem_ack
//  - imem_addr   out  XLEN  read address; stable while imem_req=1
//  - imem_ack    in   1     read data valid this cycle (only meaningful while imem_req=1)
//  - imem_rdata  in   XLEN  read data
//  - instr       out  XLEN  fetched instruction
//  - instr_pc    out  XLEN  address instr was fetched from
//  - instr_valid out  1     instr/instr_pc valid for decode
//  - instr_ready in   1     decode accepts instr this cycle
//  - pc_step     out  1     1-cycle pulse: instruction consumed, controller may advance PC
//  - fetch_fault out  1     misaligned-PC fault (see CONFIGURATION); otherwise tied 0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, imem_req=0, imem_addr=0, instr=RESET_INSTR,
//    instr_pc=0, instr_valid=0, pc_step=0, fetch_fault=0.
//  - FSM states: IDLE, BUSY, DRAIN, VALID.
//  - IDLE: if fetch_en & !flush -> BUSY; imem_addr<=pc, imem_req<=1 (PC sampled this edge).
//  - BUSY: imem_req=1, imem_addr frozen. Ack any cycle >=1 after req rises.
//    - ack & !flush -> VALID; instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0.
//    - flush & ack (same cycle) -> data discarded, instr<=RESET_INSTR, -> IDLE.
//    - flush & !ack -> DRAIN (req stays high until ack; protocol never abandoned).
//  - DRAIN: imem_req=1; on ack -> discard data, imem_req<=0, -> IDLE. Further flush ignored.
//  - VALID: instr/instr_pc stable while instr_valid=1 & !instr_ready.
//    - instr_ready & !flush -> pc_step=1 next cycle only; instr_valid<=0; -> IDLE.
//    - flush (with or without ready) -> no pc_step; instr_valid<=0, instr<=RESET_INSTR; -> IDLE.
//  - Latency: PC sample -> instr_valid = 1 + ack delay cycles (min 2: sample, ack, valid).
//  - Throughput: one instruction per >=4 cycles (no pipelined requests; at most 1 outstanding).
//  - pc_step never asserted twice for one instruction; never asserted after flush.
//  - fetch_en low: no new request from IDLE; BUSY/DRAIN/VALID complete normally.
//  - Reset mid-transaction: all outputs to reset values immediately; memory must tolerate a
//    dropped req.
//  - imem_ack outside BUSY/DRAIN: ignored.
// CONFIGURATION
//  - Macro MISALIGN_CHECK_EN.
//  - Defined: in IDLE, if fetch_en & pc[1:0]!=0 -> no request; fetch_fault<=1, instr_pc<=pc,
//    stay IDLE. fetch_fault is sticky until flush or reset; no fetch while fetch_fault=1.
//  - Undefined: pc[1:0] ignored, imem_addr<=pc unchanged; fetch_fault tied 0.
// TESTING
//  - Reset, fetch_en=1, pc=0, ack 1 cycle after req, rdata=32'h00500093, ready=1 ->
//    instr_valid with instr=32'h00500093 and instr_pc=0; one pc_step pulse; next fetch uses new pc.
//  - Ack delayed 5 cycles -> imem_req and imem_addr stable all 5 cycles;
//    instr_valid exactly 1 cycle after ack.
//  - instr_ready held 0 for 4 cycles in VALID -> instr/instr_pc unchanged, no pc_step;
//    ready=1 -> single pc_step.
//  - flush in BUSY, ack 3 cycles later -> req held to ack, data dropped, instr_valid never 1;
//    refetch at new pc=32'h100.
//  - flush and instr_ready same cycle in VALID -> no pc_step, instr_valid=0, instr=32'h00000013.
//  - MISALIGN_CHECK_EN, pc=32'h102 -> imem_req stays 0, fetch_fault=1, instr_pc=32'h102;
//    flush clears it. Without macro -> imem_addr=32'h102, fetch_fault=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch stage sitting directly after the PC register.
//
// Samples pc, issues a single read on the instruction-memory port, and holds the
// returned word for decode under a valid/ready handshake. When decode consumes
// an instruction, pc_step pulses for one cycle so the controller can advance the
// PC. A flush discards any held or in-flight instruction. An in-flight read is
// always allowed to finish (DRAIN), so the memory protocol is never abandoned.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   fetch_en             allow new fetches from IDLE
//   pc                   current PC
//   flush                discard held/in-flight instruction
//   imem_req/imem_addr   read request and address (address frozen while req=1)
//   imem_ack/imem_rdata  read completion and data
//   instr/instr_pc       fetched word and the address it came from
//   instr_valid          instr/instr_pc valid for decode
//   instr_ready          decode accepts instr
//   pc_step              one-cycle pulse after an instruction is consumed
//   fetch_fault          misaligned-PC fault (sticky until flush/reset)
//
// Build option
//   MISALIGN_CHECK_EN    when defined, a fetch from a PC with pc[1:0]!=0 is
//                        refused and fetch_fault is raised; when undefined,
//                        pc[1:0] is ignored and fetch_fault is tied 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no read outstanding, no instruction held
// BUSY  | read outstanding, result will be delivered to decode
// DRAIN | read outstanding after a flush, result will be discarded
// VALID | instruction held for decode

module instr_fetch #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            pc_step,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;
  logic            step_q, step_d;
`ifdef MISALIGN_CHECK_EN
  logic            fault_q, fault_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= RESET_INSTR;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      step_q  <= step_d;
`ifdef MISALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // The IDLE cycle in which pc_step is high does not start a fetch: the
  // controller advances pc on that cycle's closing edge, so sampling then
  // would pick up the stale PC.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    step_d  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    fault_d = fault_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef MISALIGN_CHECK_EN
        if (flush) begin
          fault_d = 1'b0;
        end else if (fetch_en && !step_q && !fault_q) begin
          if (pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            ipc_d   = pc;
          end else begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            addr_d  = pc;
          end
        end
`else
        if (fetch_en && !flush && !step_q) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          addr_d  = pc;
        end
`endif
      end

      S_BUSY: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (flush) begin
            instr_d = RESET_INSTR;
            state_d = S_IDLE;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_VALID: begin
        if (flush) begin
          valid_d = 1'b0;
          instr_d = RESET_INSTR;
          state_d = S_IDLE;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          step_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign pc_step     = step_q;
`ifdef MISALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_step;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_step     (pc_step),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (imem_req === 1'b1) break;
      @(negedge clk);
    end
    chk("wait_req", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; pc = '0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'd0);
    chk("rst_instr", instr,                NOP);
    chk("rst_ipc",   instr_pc,             32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_step",  {31'b0, pc_step},     32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic fetch, ack one cycle after req
    fetch_en = 1'b1; pc = 32'h0; instr_ready = 1'b1;
    @(negedge clk);
    chk("t1_req",  {31'b0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr,         32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_instr", instr,                32'h00500093);
    chk("t1_ipc",   instr_pc,             32'h0);
    @(negedge clk);
    chk("t1_step",   {31'b0, pc_step},     32'd1);
    chk("t1_vclr",   {31'b0, instr_valid}, 32'd0);
    pc = 32'h4;
    @(negedge clk);
    chk("t1_step1x", {31'b0, pc_step},  32'd0);
    chk("t1_noreq",  {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("t1_req2",  {31'b0, imem_req}, 32'd1);
    chk("t1_addr2", imem_addr,         32'h4);

    // ack delayed 5 cycles; req/addr stay put
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_req",  {31'b0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr,         32'h4);
    end
    imem_ack = 1'b1; imem_rdata = 32'h00a00113;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t2_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_reqlo", {31'b0, imem_req},    32'd0);

    // decode stalls 4 cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_instr", instr,                32'h00a00113);
      chk("t3_ipc",   instr_pc,             32'h4);
      chk("t3_valid", {31'b0, instr_valid}, 32'd1);
      chk("t3_nostep",{31'b0, pc_step},     32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t3_step", {31'b0, pc_step}, 32'd1);
    fetch_en = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    chk("t3_step1x", {31'b0, pc_step}, 32'd0);

    // flush in BUSY, ack 3 cycles later, refetch at 0x100
    fetch_en = 1'b1; pc = 32'h200;
    @(negedge clk);
    chk("t4_req",  {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr,         32'h200);
    flush = 1'b1; pc = 32'h100;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold",  {31'b0, imem_req},    32'd1);
      chk("t4_haddr", imem_addr,            32'h200);
      chk("t4_noval", {31'b0, instr_valid}, 32'd0);
      if (i == 2) begin
        imem_ack = 1'b1; imem_rdata = 32'hffffffff;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("t4_reqlo", {31'b0, imem_req},    32'd0);
    chk("t4_noval", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t4_req2",  {31'b0, imem_req}, 32'd1);
    chk("t4_addr2", imem_addr,         32'h100);

    // flush together with ready in VALID
    imem_ack = 1'b1; imem_rdata = 32'h00100093;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t5_valid", {31'b0, instr_valid}, 32'd1);
    chk("t5_ipc",   instr_pc,             32'h100);
    flush = 1'b1; instr_ready = 1'b1; fetch_en = 1'b0;
    @(negedge clk);
    flush = 1'b0; instr_ready = 1'b0;
    chk("t5_nostep", {31'b0, pc_step},     32'd0);
    chk("t5_vclr",   {31'b0, instr_valid}, 32'd0);
    chk("t5_instr",  instr,                NOP);
    @(negedge clk);
    chk("t5_nostep2", {31'b0, pc_step}, 32'd0);

    // stray ack in IDLE is ignored
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t6_noval", {31'b0, instr_valid}, 32'd0);
    chk("t6_noreq", {31'b0, imem_req},    32'd0);
    chk("t6_instr", instr,                NOP);

    // misaligned PC
    fetch_en = 1'b1; pc = 32'h102;
    @(negedge clk);
`ifdef MISALIGN_CHECK_EN
    chk("t7_noreq", {31'b0, imem_req},    32'd0);
    chk("t7_fault", {31'b0, fetch_fault}, 32'd1);
    chk("t7_ipc",   instr_pc,             32'h102);
    @(negedge clk);
    chk("t7_noreq2", {31'b0, imem_req},    32'd0);
    chk("t7_fault2", {31'b0, fetch_fault}, 32'd1);
    flush = 1'b1; fetch_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("t7_fclr", {31'b0, fetch_fault}, 32'd0);
    fetch_en = 1'b1; pc = 32'h40;
`else
    chk("t7_req",   {31'b0, imem_req},    32'd1);
    chk("t7_addr",  imem_addr,            32'h102);
    chk("t7_fault", {31'b0, fetch_fault}, 32'd0);
`endif

    // reset in the middle of a transaction
    wait_req(10);
    #1 rst_n = 1'b0;
    #1;
    chk("t8_req",   {31'b0, imem_req},    32'd0);
    chk("t8_addr",  imem_addr,            32'd0);
    chk("t8_valid", {31'b0, instr_valid}, 32'd0);
    chk("t8_instr", instr,                NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
